slv_guard_rst_ctrl: RTL and testbench
=====================================

SLV_GUARD_RST_CTRL -- requirements
Module: slv_guard_rst_ctrl

Interface
REQ-001 SHALL have parameter IsolateCycles, default 4: number of isolation/drain cycles before slave reset; 0 skips ISOLATE.
REQ-002 SHALL have parameter RstCycles, default 8: number of cycles slv_rst_no is held low; legal range >= 1.
REQ-003 SHALL have parameter RecoverCycles, default 2: number of settle cycles after slave reset release; 0 skips RECOVER.
REQ-004 SHALL have parameter CntWidth, default 4: width of the reset-event counter.
REQ-005 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port rst_req_i, input, 1: reset request from the slave guard (level).
REQ-008 SHALL have port rst_stat_o, output, 1: reset-complete status returned to the guard's reset-clear input (level).
REQ-009 SHALL have port slv_rst_no, output, 1: active-low reset driven to the guarded slave.
REQ-010 SHALL have port isolate_o, output, 1: request to hold the slave's AXI ports isolated.
REQ-011 SHALL have port busy_o, output, 1: high whenever a reset sequence is in progress.
REQ-012 SHALL have port clr_cnt_i, input, 1: synchronous clear of rst_cnt_o.
REQ-013 SHALL have port rst_cnt_o, output, CntWidth: number of completed slave resets, saturating.

Function
REQ-014 SHALL implement FSM states IDLE, ISOLATE, RESET, RECOVER, DONE; all outputs registered (decoded from state flops/registers, no combinational path from inputs).
REQ-015 IDLE: rst_req_i=1 sampled SHALL move to ISOLATE next cycle (or RESET if IsolateCycles=0).
REQ-016 ISOLATE SHALL last exactly IsolateCycles cycles, then move to RESET.
REQ-017 RESET SHALL last exactly RstCycles cycles with slv_rst_no=0 for exactly those cycles, then move to RECOVER (or DONE if RecoverCycles=0).
REQ-018 RECOVER SHALL last exactly RecoverCycles cycles, then move to DONE.
REQ-019 DONE SHALL hold rst_stat_o=1 and remain until rst_req_i=0 is sampled, then return to IDLE (minimum 1 cycle in DONE).
REQ-020 rst_stat_o SHALL be 1 only in DONE; slv_rst_no SHALL be 0 only in RESET.
REQ-021 isolate_o SHALL be 1 in ISOLATE, RESET, RECOVER, DONE; 0 in IDLE.
REQ-022 busy_o SHALL be 1 in every state except IDLE.
REQ-023 A single phase down-counter of width $clog2(max(IsolateCycles,RstCycles,RecoverCycles)+1) SHALL time phases, reloaded on each state entry.
REQ-024 Sequence SHALL NOT abort: rst_req_i falling during ISOLATE/RESET/RECOVER SHALL be ignored; sequence completes to DONE, then exits DONE after one cycle.
REQ-025 rst_req_i held high after DONE->IDLE SHALL NOT occur by construction; if rst_req_i is re-asserted in IDLE a new sequence SHALL start.
REQ-026 rst_cnt_o SHALL increment by 1 on the RESET->next-state transition and saturate at 2^CntWidth-1 (no wrap).
REQ-027 clr_cnt_i SHALL zero rst_cnt_o next cycle; simultaneous with increment, clear SHALL win (result 0).

Reset
REQ-028 On rst_ni=0 the FSM SHALL enter IDLE asynchronously; rst_stat_o=0, isolate_o=0, busy_o=0, rst_cnt_o=0, phase counter=0.
REQ-029 slv_rst_no SHALL be 1 during and after controller reset (slave reset is only driven by the FSM).
REQ-030 rst_ni asserted mid-sequence SHALL immediately return all outputs to reset values; no completion of the interrupted sequence.

Verification
REQ-031 Defaults, rst_req_i pulsed high at cycle 0 and held -> isolate_o/busy_o high from cycle 1, slv_rst_no low cycles 5-12, RECOVER 13-14, rst_stat_o high from cycle 15 until 1 cycle after rst_req_i drops, rst_cnt_o=1.
REQ-032 IsolateCycles=0, RecoverCycles=0, RstCycles=1 -> slv_rst_no low exactly 1 cycle, rst_stat_o high the following cycle.
REQ-033 rst_req_i dropped during RESET -> sequence completes; DONE lasts exactly 1 cycle; rst_cnt_o increments.
REQ-034 CntWidth=2, 5 back-to-back sequences -> rst_cnt_o reads 1,2,3,3,3; clr_cnt_i coincident with 6th increment -> 0.
REQ-035 rst_ni asserted at cycle 7 of a default sequence -> slv_rst_no=1, isolate_o=0, busy_o=0, rst_cnt_o=0 immediately, FSM in IDLE.

Source files
------------

// File: rtl/slv_guard_rst_ctrl.sv
// Sequences the reset of a guarded AXI slave: isolate ports, pulse the slave reset,
// let it settle, then report completion to the guard until its request drops.
module slv_guard_rst_ctrl #(
    parameter int IsolateCycles = 4,
    parameter int RstCycles     = 8,
    parameter int RecoverCycles = 2,
    parameter int CntWidth      = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                rst_req_i,
    output logic                rst_stat_o,
    output logic                slv_rst_no,
    output logic                isolate_o,
    output logic                busy_o,
    input  logic                clr_cnt_i,
    output logic [CntWidth-1:0] rst_cnt_o
);

    localparam int MaxIR  = (IsolateCycles > RstCycles) ? IsolateCycles : RstCycles;
    localparam int MaxCyc = (MaxIR > RecoverCycles) ? MaxIR : RecoverCycles;
    localparam int PhW    = (MaxCyc < 1) ? 1 : $clog2(MaxCyc + 1);

    // Phase counter holds "cycles remaining minus one"; leaving the phase happens at zero.
    localparam logic [PhW-1:0] IsoLd = PhW'((IsolateCycles > 0) ? IsolateCycles - 1 : 0);
    localparam logic [PhW-1:0] RstLd = PhW'((RstCycles > 0) ? RstCycles - 1 : 0);
    localparam logic [PhW-1:0] RecLd = PhW'((RecoverCycles > 0) ? RecoverCycles - 1 : 0);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISOLATE = 3'd1,
        RESET   = 3'd2,
        RECOVER = 3'd3,
        DONE    = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [PhW-1:0]      ph_q, ph_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                cnt_inc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ph_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        cnt_inc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rst_req_i) begin
                    if (IsolateCycles > 0) begin
                        state_d = ISOLATE;
                        ph_d    = IsoLd;
                    end else begin
                        state_d = RESET;
                        ph_d    = RstLd;
                    end
                end
            end
            ISOLATE: begin
                if (ph_q == '0) begin
                    state_d = RESET;
                    ph_d    = RstLd;
                end else begin
                    ph_d = ph_q - PhW'(1);
                end
            end
            RESET: begin
                if (ph_q == '0) begin
                    cnt_inc = 1'b1;
                    if (RecoverCycles > 0) begin
                        state_d = RECOVER;
                        ph_d    = RecLd;
                    end else begin
                        state_d = DONE;
                        ph_d    = '0;
                    end
                end else begin
                    ph_d = ph_q - PhW'(1);
                end
            end
            RECOVER: begin
                if (ph_q == '0) begin
                    state_d = DONE;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q - PhW'(1);
                end
            end
            DONE: begin
                // Request level is ignored until here, so a started sequence always completes.
                if (!rst_req_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ph_d    = '0;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt_i) begin
            cnt_d = '0;
        end else if (cnt_inc && (cnt_q != {CntWidth{1'b1}})) begin
            cnt_d = cnt_q + CntWidth'(1);
        end
    end

    assign rst_stat_o = (state_q == DONE);
    assign slv_rst_no = (state_q != RESET);
    assign isolate_o  = (state_q != IDLE);
    assign busy_o     = (state_q != IDLE);
    assign rst_cnt_o  = cnt_q;

endmodule

// File: tb/tb_slv_guard_rst_ctrl.sv
// Directed bench for slv_guard_rst_ctrl: default timing, aborted request, controller reset
// mid-sequence, minimal-phase configuration and counter saturation/clear.
module tb_slv_guard_rst_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Instance A: defaults
    logic       a_req, a_clr, a_stat, a_srst, a_iso, a_busy;
    logic [3:0] a_cnt;
    slv_guard_rst_ctrl u_a (
        .clk_i(clk), .rst_ni(rst_n), .rst_req_i(a_req), .rst_stat_o(a_stat),
        .slv_rst_no(a_srst), .isolate_o(a_iso), .busy_o(a_busy),
        .clr_cnt_i(a_clr), .rst_cnt_o(a_cnt)
    );

    // Instance B: no isolate, 1-cycle reset, no recover
    logic       b_req, b_clr, b_stat, b_srst, b_iso, b_busy;
    logic [3:0] b_cnt;
    slv_guard_rst_ctrl #(.IsolateCycles(0), .RstCycles(1), .RecoverCycles(0)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .rst_req_i(b_req), .rst_stat_o(b_stat),
        .slv_rst_no(b_srst), .isolate_o(b_iso), .busy_o(b_busy),
        .clr_cnt_i(b_clr), .rst_cnt_o(b_cnt)
    );

    // Instance C: 2-bit counter, short phases (ISO c1, RESET c2-3, RECOVER c4, DONE c5)
    logic       c_req, c_clr, c_stat, c_srst, c_iso, c_busy;
    logic [1:0] c_cnt;
    slv_guard_rst_ctrl #(.IsolateCycles(1), .RstCycles(2), .RecoverCycles(1), .CntWidth(2)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .rst_req_i(c_req), .rst_stat_o(c_stat),
        .slv_rst_no(c_srst), .isolate_o(c_iso), .busy_o(c_busy),
        .clr_cnt_i(c_clr), .rst_cnt_o(c_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input int c, input logic st, input logic sr, input logic iso, input int cnt);
        chk($sformatf("A c%0d stat", c), 32'(a_stat), 32'(st));
        chk($sformatf("A c%0d srst", c), 32'(a_srst), 32'(sr));
        chk($sformatf("A c%0d iso", c),  32'(a_iso),  32'(iso));
        chk($sformatf("A c%0d busy", c), 32'(a_busy), 32'(iso));
        chk($sformatf("A c%0d cnt", c),  32'(a_cnt),  32'(cnt));
    endtask

    // One complete sequence on C; clr_at_inc drives clear on the cycle of the increment edge.
    task automatic run_c(input int k, input int exp_cnt, input bit clr_at_inc);
        c_req = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            if (c == 4) c_clr = clr_at_inc;
            step();
            if (c == 4) begin
                c_clr = 1'b0;
                chk($sformatf("C seq%0d cnt", k), 32'(c_cnt), 32'(exp_cnt));
            end
        end
        chk($sformatf("C seq%0d stat", k), 32'(c_stat), 32'd1);
        c_req = 1'b0;
        step();
        chk($sformatf("C seq%0d idle", k), 32'(c_busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        a_req = 0; a_clr = 0; b_req = 0; b_clr = 0; c_req = 0; c_clr = 0;
        #12;
        chk("rst A", {a_stat, a_srst, a_iso, a_busy, a_cnt}, {1'b0, 1'b1, 1'b0, 1'b0, 4'd0});
        chk("rst B", {b_stat, b_srst, b_iso, b_busy, b_cnt}, {1'b0, 1'b1, 1'b0, 1'b0, 4'd0});
        chk("rst C", {c_stat, c_srst, c_iso, c_busy, c_cnt}, {1'b0, 1'b1, 1'b0, 1'b0, 2'd0});
        step();
        rst_n = 1'b1;
        step();
        chk_a(0, 0, 1, 0, 0);

        // Default sequence, request held through DONE and dropped at cycle 17
        a_req = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            step();
            chk_a(c, (c >= 15 && c <= 17), !(c >= 5 && c <= 12), (c <= 17), (c >= 13) ? 1 : 0);
            if (c == 17) a_req = 1'b0;
        end

        // Request dropped during RESET: completes, DONE lasts one cycle
        a_req = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            step();
            if (c == 6) a_req = 1'b0;
            chk_a(c, (c == 15), !(c >= 5 && c <= 12), (c <= 15), (c >= 13) ? 2 : 1);
        end

        // Controller reset mid-sequence (cycle 7, slave reset active)
        a_req = 1'b1;
        for (int c = 1; c <= 7; c++) step();
        chk("A pre-abort srst", 32'(a_srst), 32'd0);
        rst_n = 1'b0;
        #1;
        chk_a(100, 0, 1, 0, 0);
        a_req = 1'b0;
        step();
        rst_n = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            chk_a(100 + c, 0, 1, 0, 0);
        end

        // Minimal configuration
        b_req = 1'b1;
        step();
        chk("B c1", {b_stat, b_srst, b_iso, b_busy}, {1'b0, 1'b0, 1'b1, 1'b1});
        step();
        chk("B c2", {b_stat, b_srst, b_iso, b_busy}, {1'b1, 1'b1, 1'b1, 1'b1});
        chk("B c2 cnt", 32'(b_cnt), 32'd1);
        b_req = 1'b0;
        step();
        chk("B c3", {b_stat, b_srst, b_iso, b_busy}, {1'b0, 1'b1, 1'b0, 1'b0});

        // Saturating counter and clear-wins
        run_c(1, 1, 1'b0);
        run_c(2, 2, 1'b0);
        run_c(3, 3, 1'b0);
        run_c(4, 3, 1'b0);
        run_c(5, 3, 1'b0);
        run_c(6, 0, 1'b1);
        step();
        chk("C after clr", 32'(c_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
